// File: rtl/clz_norm_pipe.sv
`default_nettype none
// ============================================================================
// Module   : clz_norm_pipe
// Purpose  : Leading-zero count, normalising left shift and exponent adjust
//            over a valid/ready stream. Build macro CLZ_NORM_TWO_STAGE_EN
//            selects the two-register pipeline (default: single stage).
// Revision : 1.0
// ============================================================================
module clz_norm_pipe #(
  parameter  int DATA_W = 32,
  parameter  int EXP_W  = 8,
  localparam int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_lz,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero,
  output logic              out_uflow
);

  localparam int LVLS  = $clog2(DATA_W);
  localparam int CMP_W = (CNT_W > EXP_W) ? CNT_W : EXP_W;

  logic [CNT_W-1:0] lz;

  // Halving tree: each level keeps whichever half still holds the leading one.
  for (genvar l = 0; l < LVLS; l++) begin : g_lvl
    localparam int W = DATA_W >> l;
    localparam int H = W / 2;

    logic [W-1:0]     cur;
    logic [CNT_W-1:0] acc_prev;
    logic             upper_zero;
    logic [H-1:0]     nxt;
    logic [CNT_W-1:0] acc;

    if (l == 0) begin : g_first
      assign cur      = in_data;
      assign acc_prev = '0;
    end else begin : g_rest
      assign cur      = g_lvl[l-1].nxt;
      assign acc_prev = g_lvl[l-1].acc;
    end

    assign upper_zero = (cur[W-1:H] == '0);
    assign nxt        = upper_zero ? cur[H-1:0] : cur[W-1:H];
    assign acc        = acc_prev + (upper_zero ? CNT_W'(H) : CNT_W'(0));
  end

  // The final surviving bit being zero means the whole word was zero.
  assign lz = g_lvl[LVLS-1].acc + CNT_W'(!g_lvl[LVLS-1].nxt[0]);

  logic [DATA_W-1:0] src_data;
  logic [EXP_W-1:0]  src_exp;
  logic [CNT_W-1:0]  src_lz;
  logic              src_valid;
  logic              out_adv;

  logic [CMP_W-1:0]  lz_x;
  logic [CMP_W-1:0]  exp_x;
  logic [CMP_W-1:0]  shamt;
  logic [DATA_W-1:0] n_data;
  logic [EXP_W-1:0]  n_exp;
  logic              n_zero;
  logic              n_uflow;

  always_comb begin
    lz_x    = CMP_W'(src_lz);
    exp_x   = CMP_W'(src_exp);
    shamt   = (lz_x < exp_x) ? lz_x : exp_x;
    n_zero  = (src_lz == CNT_W'(DATA_W));
    n_uflow = (lz_x > exp_x) && !n_zero;
    n_data  = n_zero ? '0 : (src_data << shamt);
    n_exp   = n_zero ? '0 : (src_exp - EXP_W'(shamt));
  end

`ifdef CLZ_NORM_TWO_STAGE_EN
  logic              v1_q,    v1_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic [EXP_W-1:0]  exp1_q,  exp1_d;
  logic [CNT_W-1:0]  lz1_q,   lz1_d;
  logic              s2_ready;

  assign s2_ready  = !out_valid || out_ready;
  assign in_ready  = !v1_q || s2_ready;
  assign out_adv   = s2_ready;
  assign src_valid = v1_q;
  assign src_data  = data1_q;
  assign src_exp   = exp1_q;
  assign src_lz    = lz1_q;

  always_comb begin
    v1_d    = v1_q;
    data1_d = data1_q;
    exp1_d  = exp1_q;
    lz1_d   = lz1_q;
    if (in_ready) begin
      v1_d = in_valid;
      if (in_valid) begin
        data1_d = in_data;
        exp1_d  = in_exp;
        lz1_d   = lz;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      data1_q <= '0;
      exp1_q  <= '0;
      lz1_q   <= '0;
    end else begin
      v1_q    <= v1_d;
      data1_q <= data1_d;
      exp1_q  <= exp1_d;
      lz1_q   <= lz1_d;
    end
  end
`else
  assign in_ready  = !out_valid || out_ready;
  assign out_adv   = in_ready;
  assign src_valid = in_valid;
  assign src_data  = in_data;
  assign src_exp   = in_exp;
  assign src_lz    = lz;
`endif

  logic              ov_q,    ov_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic [CNT_W-1:0]  olz_q,   olz_d;
  logic [EXP_W-1:0]  oexp_q,  oexp_d;
  logic              ozero_q, ozero_d;
  logic              ouf_q,   ouf_d;

  // Output register only moves when it is empty or being drained.
  always_comb begin
    ov_d    = ov_q;
    odata_d = odata_q;
    olz_d   = olz_q;
    oexp_d  = oexp_q;
    ozero_d = ozero_q;
    ouf_d   = ouf_q;
    if (out_adv) begin
      ov_d = src_valid;
      if (src_valid) begin
        odata_d = n_data;
        olz_d   = src_lz;
        oexp_d  = n_exp;
        ozero_d = n_zero;
        ouf_d   = n_uflow;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q    <= 1'b0;
      odata_q <= '0;
      olz_q   <= '0;
      oexp_q  <= '0;
      ozero_q <= 1'b0;
      ouf_q   <= 1'b0;
    end else begin
      ov_q    <= ov_d;
      odata_q <= odata_d;
      olz_q   <= olz_d;
      oexp_q  <= oexp_d;
      ozero_q <= ozero_d;
      ouf_q   <= ouf_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = odata_q;
  assign out_lz    = olz_q;
  assign out_exp   = oexp_q;
  assign out_zero  = ozero_q;
  assign out_uflow = ouf_q;

endmodule

`default_nettype wire

// File: tb/tb_clz_norm_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_clz_norm_pipe
// Purpose  : Self-checking bench for clz_norm_pipe (DATA_W=32, EXP_W=8).
// Revision : 1.0
// ============================================================================
module tb_clz_norm_pipe;

  localparam int DW = 32;
  localparam int EW = 8;
  localparam int CW = 6;
`ifdef CLZ_NORM_TWO_STAGE_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [EW-1:0] in_exp = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_lz;
  logic [EW-1:0] out_exp;
  logic          out_zero;
  logic          out_uflow;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] lz;
    logic [EW-1:0] exp;
    logic          zero;
    logic          uflow;
  } res_t;

  res_t exp_q[$];

  clz_norm_pipe #(.DATA_W(DW), .EXP_W(EW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lz(out_lz), .out_exp(out_exp), .out_zero(out_zero), .out_uflow(out_uflow)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [DW-1:0] d, input logic [EW-1:0] e);
    res_t r;
    int   n  = 0;
    int   sh;
    while (n < DW && d[DW-1-n] == 1'b0) n++;
    sh      = (n < int'(e)) ? n : int'(e);
    r.lz    = CW'(n);
    r.zero  = (n == DW);
    r.data  = r.zero ? '0 : (d << sh);
    r.exp   = r.zero ? '0 : (e - EW'(sh));
    r.uflow = !r.zero && (n > int'(e));
    return r;
  endfunction

  function automatic res_t observe();
    return {out_data, out_lz, out_exp, out_zero, out_uflow};
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d = $urandom;
    int            s = $urandom_range(0, DW);
    return (s == DW) ? '0 : (d >> s);
  endfunction

  function automatic logic [EW-1:0] rand_exp();
    return ($urandom_range(0, 3) == 0) ? EW'($urandom_range(0, 40)) : EW'($urandom_range(0, 255));
  endfunction

  task automatic send_one(input logic [DW-1:0] d, input logic [EW-1:0] e,
                          output res_t r, output int lat);
    int g = 0;
    out_ready = 1'b1;
    in_data   = d;
    in_exp    = e;
    in_valid  = 1'b1;
    @(negedge clk);
    while (!in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = observe();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #3 rst_n = 1'b0;
    #4;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready  !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_data  !== '0)   begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (out_lz    !== '0)   begin errors++; $display("FAIL reset_out_lz: got %0d want 0", out_lz); end
    checks++; if (out_exp   !== '0)   begin errors++; $display("FAIL reset_out_exp: got %0d want 0", out_exp); end
    checks++; if (out_zero  !== 1'b0) begin errors++; $display("FAIL reset_out_zero: got %b want 0", out_zero); end
    checks++; if (out_uflow !== 1'b0) begin errors++; $display("FAIL reset_out_uflow: got %b want 0", out_uflow); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [DW-1:0] dv [6];
    logic [EW-1:0] ev [6];
    res_t          want [6];
    res_t          got;
    int            lat;
    dv = '{32'h0000_0001, 32'h8000_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0003, 32'hFFFF_FFFF};
    ev = '{8'd100, 8'd5, 8'd10, 8'd77, 8'd0, 8'd0};
    want = '{
      '{data: 32'h8000_0000, lz: 6'd31, exp: 8'd69, zero: 1'b0, uflow: 1'b0},
      '{data: 32'h8000_0000, lz: 6'd0,  exp: 8'd5,  zero: 1'b0, uflow: 1'b0},
      '{data: 32'h0400_0000, lz: 6'd15, exp: 8'd0,  zero: 1'b0, uflow: 1'b1},
      '{data: 32'h0000_0000, lz: 6'd32, exp: 8'd0,  zero: 1'b1, uflow: 1'b0},
      '{data: 32'h0000_0003, lz: 6'd30, exp: 8'd0,  zero: 1'b0, uflow: 1'b1},
      '{data: 32'hFFFF_FFFF, lz: 6'd0,  exp: 8'd0,  zero: 1'b0, uflow: 1'b0}
    };
    for (int i = 0; i < 6; i++) begin
      send_one(dv[i], ev[i], got, lat);
      checks++;
      if (got !== want[i]) begin
        errors++;
        $display("FAIL directed_%0d result: got %h want %h", i, got, want[i]);
      end
      checks++;
      if (lat !== DEPTH) begin
        errors++;
        $display("FAIL directed_%0d latency: got %0d want %0d", i, lat, DEPTH);
      end
    end
  endtask

  // mode 0: random valid/ready, 1: out_ready low in cycles 2..5, 2: all ready
  task automatic run_stream(input string name, input int n, input int mode,
                            output int cyc, output int stalls);
    int   sent  = 0;
    int   recv  = 0;
    int   c     = 0;
    logic acc   = 1'b0;
    logic stall = 1'b0;
    res_t held  = '0;
    res_t got;
    res_t want;
    stalls   = 0;
    in_valid = 1'b0;
    while (recv < n && c < 40 * n + 100) begin
      if (!in_valid || acc) begin
        if (sent < n && (mode != 0 || $urandom_range(0, 3) != 0)) begin
          in_data  = rand_data();
          in_exp   = rand_exp();
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      case (mode)
        0:       out_ready = ($urandom_range(0, 2) != 0);
        1:       out_ready = !(c >= 2 && c <= 5);
        default: out_ready = 1'b1;
      endcase
      @(negedge clk);
      got = observe();
      if (!in_ready) stalls++;
      checks++;
      if (in_ready !== !(exp_q.size() == DEPTH && !out_ready)) begin
        errors++;
        $display("FAIL %s in_ready cyc %0d: got %b want %b", name, c, in_ready,
                 !(exp_q.size() == DEPTH && !out_ready));
      end
      if (stall) begin
        checks++;
        if (out_valid !== 1'b1 || got !== held) begin
          errors++;
          $display("FAIL %s hold cyc %0d: got v=%b %h want v=1 %h", name, c, out_valid, got, held);
        end
      end
      stall = out_valid && !out_ready;
      held  = got;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s spurious output cyc %0d: got %h want none", name, c, got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL %s result %0d: got %h want %h", name, recv, got, want);
          end
        end
        recv++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        exp_q.push_back(model(in_data, in_exp));
        sent++;
      end
      @(posedge clk); #1;
      c++;
    end
    in_valid = 1'b0;
    cyc      = c;
    checks++;
    if (recv != n || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s count: got %0d results (%0d pending) want %0d", name, recv, exp_q.size(), n);
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    int cyc, st;
    run_stream("random", 300, 0, cyc, st);
  endtask

  task automatic test_backpressure();
    int cyc, st;
    run_stream("backpressure", 6, 1, cyc, st);
    checks++;
    if (st == 0) begin
      errors++;
      $display("FAIL backpressure in_ready_low: got %0d stalled cycles want >0", st);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, st;
    run_stream("back_to_back", 20, 2, cyc, st);
    checks++;
    if (cyc != 20 + DEPTH) begin
      errors++;
      $display("FAIL back_to_back throughput: got %0d cycles want %0d", cyc, 20 + DEPTH);
    end
    checks++;
    if (st != 0) begin
      errors++;
      $display("FAIL back_to_back in_ready: got %0d stalled cycles want 0", st);
    end
  endtask

  task automatic test_reset_midflight();
    res_t got;
    int   lat;
    logic [DW-1:0] cd = 32'h0002_5A00;
    logic [EW-1:0] ce = 8'd40;
    out_ready = 1'b0;
    in_data   = 32'h00F0_0000;
    in_exp    = 8'd50;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_data = 32'h0000_0ABC;
    in_exp  = 8'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready  !== 1'b1) begin errors++; $display("FAIL midreset in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset stale_beat %0d: got out_valid %b want 0", i, out_valid);
      end
      @(posedge clk); #1;
    end
    send_one(cd, ce, got, lat);
    checks++;
    if (got !== model(cd, ce)) begin
      errors++;
      $display("FAIL midreset first_result: got %h want %h", got, model(cd, ce));
    end
    checks++;
    if (lat !== DEPTH) begin
      errors++;
      $display("FAIL midreset latency: got %0d want %0d", lat, DEPTH);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
